puzzle_move_ctrl: RTL and testbench



---
 rtl/puzzle_move_ctrl_if.sv | 20 ++
 rtl/puzzle_move_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_puzzle_move_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/puzzle_move_ctrl_if.sv
// rtl/puzzle_move_ctrl_if.sv - shared board write-port bundle between move controller and register file
interface puzzle_move_ctrl_if #(
  parameter int BOARD_W = 40
);
  logic               brd_req;
  logic               brd_gnt;
  logic               brd_we;
  logic [BOARD_W-1:0] brd_wdata;
  logic [BOARD_W-1:0] brd_rdata;

  modport master (
    output brd_req, brd_we, brd_wdata,
    input  brd_gnt, brd_rdata
  );

  modport slave (
    input  brd_req, brd_we, brd_wdata,
    output brd_gnt, brd_rdata
  );
endinterface

// File: rtl/puzzle_move_ctrl.sv
// rtl/puzzle_move_ctrl.sv - 8-puzzle move sequencer (snapshot, locate, check, write, update)
// Optional undo history enabled by defining MOVE_UNDO_EN.
module puzzle_move_ctrl #(
  parameter int BOARD_W    = 40,
  parameter int CNT_MAX    = 9999,
  parameter int HIST_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         btn,
  input  logic               undo,
  input  logic               cpu_busy,
  puzzle_move_ctrl_if.master brd,
  output logic               cpu_start,
  output logic [13:0]        move_cnt,
  output logic               solved,
  output logic               illegal,
  output logic               err,
  output logic               busy
);
  localparam logic [BOARD_W-1:0] GOAL    = BOARD_W'(40'h0087654321);
  localparam logic [13:0]        CNT_TOP = 14'(CNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_LOCATE, S_CHECK, S_WRITE, S_UPDATE} state_t;

  state_t             state;
  logic [4:0]         btn_q, btn_qq, press;
  logic [1:0]         dir, arrow_dir;
  logic [3:0]         pos, tgt, nib;
  logic [BOARD_W-1:0] snap, wdata, swapped;
  logic               req, legal, arrow_any;

`ifdef MOVE_UNDO_EN
  localparam int HCW = $clog2(HIST_DEPTH + 1);
  logic [1:0]     hist [HIST_DEPTH];
  logic [HCW-1:0] hist_cnt;
  logic           undo_q, undo_qq, undo_press, is_undo;
  assign undo_press = undo_q & ~undo_qq;
`else
  logic unused_undo;
  assign unused_undo = undo ^ (HIST_DEPTH == 0);
`endif

  assign press     = btn_q & ~btn_qq;
  assign arrow_any = |press[3:0];
  assign arrow_dir = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  assign nib       = snap[{pos, 2'b00} +: 4];

  assign busy          = (state != S_IDLE);
  assign brd.brd_req   = req;
  assign brd.brd_we    = req & brd.brd_gnt;
  assign brd.brd_wdata = wdata;

  // dir: 0 up, 1 down, 2 left, 3 right; the inverse direction is dir ^ 1
  always_comb begin
    legal   = 1'b0;
    tgt     = pos;
    swapped = snap;
    case (dir)
      2'd0:    begin legal = (pos < 4'd6);  tgt = pos + 4'd3; end
      2'd1:    begin legal = (pos >= 4'd3); tgt = pos - 4'd3; end
      2'd2:    begin legal = (pos != 4'd2) && (pos != 4'd5) && (pos != 4'd8); tgt = pos + 4'd1; end
      default: begin legal = (pos != 4'd0) && (pos != 4'd3) && (pos != 4'd6); tgt = pos - 4'd1; end
    endcase
    if (legal) begin
      swapped[{pos, 2'b00} +: 4] = snap[{tgt, 2'b00} +: 4];
      swapped[{tgt, 2'b00} +: 4] = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      btn_q     <= '0;
      btn_qq    <= '0;
      dir       <= '0;
      pos       <= '0;
      snap      <= '0;
      wdata     <= '0;
      req       <= 1'b0;
      cpu_start <= 1'b0;
      move_cnt  <= '0;
      solved    <= 1'b0;
      illegal   <= 1'b0;
      err       <= 1'b0;
`ifdef MOVE_UNDO_EN
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 2'd0;
      hist_cnt <= '0;
      undo_q   <= 1'b0;
      undo_qq  <= 1'b0;
      is_undo  <= 1'b0;
`endif
    end else begin
      btn_q     <= btn;
      btn_qq    <= btn_q;
      cpu_start <= 1'b0;
      illegal   <= 1'b0;
`ifdef MOVE_UNDO_EN
      undo_q    <= undo;
      undo_qq   <= undo_q;
`endif
      case (state)
        S_IDLE: begin
          solved <= (brd.brd_rdata == GOAL);
          if (press[4]) begin
            move_cnt  <= '0;
            err       <= 1'b0;
            cpu_start <= ~cpu_busy;
`ifdef MOVE_UNDO_EN
            hist_cnt  <= '0;
`endif
          end
`ifdef MOVE_UNDO_EN
          else if (undo_press && !cpu_busy) begin
            if (hist_cnt == '0) begin
              illegal <= 1'b1;
            end else begin
              dir      <= hist[0] ^ 2'b01;
              is_undo  <= 1'b1;
              snap     <= brd.brd_rdata;
              pos      <= '0;
              state    <= S_LOCATE;
              hist_cnt <= hist_cnt - HCW'(1);
              for (int i = 0; i < HIST_DEPTH - 1; i++) hist[i] <= hist[i+1];
              hist[HIST_DEPTH-1] <= 2'd0;
            end
          end
`endif
          else if (arrow_any && !cpu_busy) begin
            dir   <= arrow_dir;
            snap  <= brd.brd_rdata;
            pos   <= '0;
            state <= S_LOCATE;
`ifdef MOVE_UNDO_EN
            is_undo <= 1'b0;
`endif
          end
        end
        S_LOCATE: begin
          if (nib == 4'h0) begin
            state <= S_CHECK;
          end else if (pos == 4'd8) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            pos <= pos + 4'd1;
          end
        end
        S_CHECK: begin
          if (legal) begin
            wdata <= swapped;
            req   <= 1'b1;
            state <= S_WRITE;
          end else begin
            illegal <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_WRITE: begin
          // brd_we is req & gnt, so dropping req here limits the strobe to one cycle
          if (brd.brd_gnt) begin
            req   <= 1'b0;
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          solved <= (wdata == GOAL);
          state  <= S_IDLE;
`ifdef MOVE_UNDO_EN
          if (is_undo) begin
            if (move_cnt != '0) move_cnt <= move_cnt - 14'd1;
          end else begin
            if (move_cnt < CNT_TOP) move_cnt <= move_cnt + 14'd1;
            for (int i = HIST_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= dir;
            if (hist_cnt != HCW'(HIST_DEPTH)) hist_cnt <= hist_cnt + HCW'(1);
          end
`else
          if (move_cnt < CNT_TOP) move_cnt <= move_cnt + 14'd1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// tb/tb_puzzle_move_ctrl.sv - directed vector bench for puzzle_move_ctrl with a register-file model
module tb_puzzle_move_ctrl;
  localparam logic [39:0] GOAL = 40'h0087654321;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = 5'd0;
  logic        undo = 1'b0;
  logic        cpu_busy = 1'b0;
  logic        gnt = 1'b1;
  logic        ld = 1'b0;
  logic [39:0] ld_val = 40'd0;
  logic [39:0] board = 40'd0;
  logic        cpu_start, solved, illegal, err, busy;
  logic [13:0] move_cnt;

  int checks = 0;
  int errors = 0;
  int we_n, ill_n, req_n, busy_n, st_n, we_lat;
  logic [39:0] wd;
  int exp_cnt;

  puzzle_move_ctrl_if bi ();
  assign bi.brd_rdata = board;
  assign bi.brd_gnt   = gnt;

  puzzle_move_ctrl #(.BOARD_W(40), .CNT_MAX(9999), .HIST_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .undo(undo), .cpu_busy(cpu_busy), .brd(bi),
    .cpu_start(cpu_start), .move_cnt(move_cnt), .solved(solved),
    .illegal(illegal), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) board <= ld_val;
    else if (bi.brd_we) board <= bi.brd_wdata;
  end

  typedef struct {
    logic [39:0] brd;
    logic [4:0]  b;
    int          wr;
    logic [39:0] wdata;
    int          lat;
    int          busyc;
    int          ill;
    logic        e;
    logic        sol;
    int          cnt;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load_board(input logic [39:0] v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b, input logic u, input int win);
    we_n = 0; ill_n = 0; req_n = 0; busy_n = 0; st_n = 0; we_lat = -1; wd = '0;
    @(negedge clk);
    btn = b;
    undo = u;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (k == 1) begin btn = 5'd0; undo = 1'b0; end
      if (bi.brd_we) begin
        we_n++;
        wd = bi.brd_wdata;
        if (we_lat < 0) we_lat = k - 1;
      end
      ill_n  += int'(illegal);
      req_n  += int'(bi.brd_req);
      busy_n += int'(busy);
      st_n   += int'(cpu_start);
    end
  endtask

  // blank shuttles between positions 0 and 1 with left/right presses on every other cycle
  task automatic run_moves(input int n);
    int done = 0;
    int cyc = 0;
    logic tog = 1'b0;
    while (done < n && cyc < n * 16) begin
      @(negedge clk);
      cyc++;
      if (bi.brd_we) done++;
      if (done >= n) begin
        btn = 5'd0;
      end else begin
        tog = ~tog;
        btn = tog ? ((board[3:0] == 4'h0) ? 5'b00100 : 5'b01000) : 5'b00000;
      end
    end
    btn = 5'd0;
    chk("moves_done", 64'(done), 64'(n));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    //            board            btn       wr wdata            lat busy ill err sol cnt
    vt[0]  = '{GOAL,             5'b00010, 1, 40'h0687054321, 11, 12, 0, 0, 0, 1};
    vt[1]  = '{GOAL,             5'b00001, 0, 40'h0,           0, 10, 1, 0, 1, 1};
    vt[2]  = '{GOAL,             5'b00100, 0, 40'h0,           0, 10, 1, 0, 1, 1};
    vt[3]  = '{GOAL,             5'b01000, 1, 40'h0807654321, 11, 12, 0, 0, 0, 2};
    vt[4]  = '{40'h0876543210,   5'b00001, 1, 40'h0876540213,  3,  4, 0, 0, 0, 3};
    vt[5]  = '{40'h0876543210,   5'b00100, 1, 40'h0876543201,  3,  4, 0, 0, 0, 4};
    vt[6]  = '{40'h0876543210,   5'b00010, 0, 40'h0,           0,  2, 1, 0, 0, 4};
    vt[7]  = '{40'h0876543210,   5'b01000, 0, 40'h0,           0,  2, 1, 0, 0, 4};
    vt[8]  = '{40'h0876504321,   5'b00010, 1, 40'h0876524301,  7,  8, 0, 0, 0, 5};
    vt[9]  = '{40'h0876504321,   5'b00101, 1, 40'h0806574321,  7,  8, 0, 0, 0, 6};
    vt[10] = '{40'h0187654321,   5'b00100, 0, 40'h0,           0,  9, 0, 1, 0, 6};

    repeat (3) @(negedge clk);
    chk("rst_req", 64'(bi.brd_req), 64'd0);
    chk("rst_we", 64'(bi.brd_we), 64'd0);
    chk("rst_wdata", 64'(bi.brd_wdata), 64'd0);
    chk("rst_outs", 64'({cpu_start, solved, illegal, err, busy}), 64'd0);
    chk("rst_cnt", 64'(move_cnt), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      load_board(vt[i].brd);
      press(vt[i].b, 1'b0, 20);
      chk($sformatf("v%0d_writes", i), 64'(we_n), 64'(vt[i].wr));
      if (vt[i].wr != 0) begin
        chk($sformatf("v%0d_wdata", i), 64'(wd), 64'(vt[i].wdata));
        chk($sformatf("v%0d_lat", i), 64'(we_lat), 64'(vt[i].lat));
      end else begin
        chk($sformatf("v%0d_req", i), 64'(req_n), 64'd0);
      end
      chk($sformatf("v%0d_busy", i), 64'(busy_n), 64'(vt[i].busyc));
      chk($sformatf("v%0d_illegal", i), 64'(ill_n), 64'(vt[i].ill));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].e));
      chk($sformatf("v%0d_solved", i), 64'(solved), 64'(vt[i].sol));
      chk($sformatf("v%0d_cnt", i), 64'(move_cnt), 64'(vt[i].cnt));
    end

    press(5'b10000, 1'b0, 6);
    chk("ctr_start", 64'(st_n), 64'd1);
    chk("ctr_err", 64'(err), 64'd0);
    chk("ctr_cnt", 64'(move_cnt), 64'd0);
    chk("ctr_busy", 64'(busy_n), 64'd0);

    // grant withheld for 5 cycles
    gnt = 1'b0;
    load_board(GOAL);
    @(negedge clk);
    btn = 5'b00010;
    @(negedge clk);
    btn = 5'd0;
    begin
      int w = 0;
      while (!bi.brd_req && w < 20) begin @(negedge clk); w++; end
      chk("gnt_req_rise", 64'(bi.brd_req), 64'd1);
    end
    for (int k = 0; k < 5; k++) begin
      chk("gnt_wait_req", 64'(bi.brd_req), 64'd1);
      chk("gnt_wait_we", 64'(bi.brd_we), 64'd0);
      chk("gnt_wait_wdata", 64'(bi.brd_wdata), 64'h0687054321);
      @(negedge clk);
    end
    gnt = 1'b1;
    #1;
    chk("gnt_we_high", 64'(bi.brd_we), 64'd1);
    @(negedge clk);
    chk("gnt_we_low", 64'(bi.brd_we), 64'd0);
    chk("gnt_req_low", 64'(bi.brd_req), 64'd0);
    repeat (3) @(negedge clk);
    chk("gnt_cnt", 64'(move_cnt), 64'd1);

    cpu_busy = 1'b1;
    load_board(GOAL);
    press(5'b01000, 1'b0, 10);
    chk("cbusy_busy", 64'(busy_n), 64'd0);
    chk("cbusy_req", 64'(req_n), 64'd0);
    chk("cbusy_cnt", 64'(move_cnt), 64'd1);
    cpu_busy = 1'b0;

    press(5'b10000, 1'b0, 4);
    load_board(40'h0876543210);
    run_moves(9999);
    chk("sat_9999", 64'(move_cnt), 64'd9999);
    run_moves(1);
    chk("sat_hold", 64'(move_cnt), 64'd9999);

    // reset while waiting for the grant
    gnt = 1'b0;
    load_board(GOAL);
    @(negedge clk);
    btn = 5'b00010;
    @(negedge clk);
    btn = 5'd0;
    begin
      int w = 0;
      while (!bi.brd_req && w < 20) begin @(negedge clk); w++; end
      chk("rstw_req_rise", 64'(bi.brd_req), 64'd1);
    end
    rst = 1'b1;
    #1;
    chk("rstw_req", 64'(bi.brd_req), 64'd0);
    chk("rstw_cnt", 64'(move_cnt), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstw_solved", 64'(solved), 64'd1);

    press(5'b00010, 1'b0, 20);
    chk("pre_undo_wdata", 64'(wd), 64'h0687054321);
    chk("pre_undo_cnt", 64'(move_cnt), 64'd1);
`ifdef MOVE_UNDO_EN
    press(5'd0, 1'b1, 20);
    chk("undo_writes", 64'(we_n), 64'd1);
    chk("undo_wdata", 64'(wd), 64'(GOAL));
    chk("undo_cnt", 64'(move_cnt), 64'd0);
    chk("undo_solved", 64'(solved), 64'd1);
    press(5'd0, 1'b1, 10);
    chk("undo_empty_ill", 64'(ill_n), 64'd1);
    chk("undo_empty_we", 64'(we_n), 64'd0);
`else
    press(5'd0, 1'b1, 10);
    chk("undo_off_busy", 64'(busy_n), 64'd0);
    chk("undo_off_ill", 64'(ill_n), 64'd0);
    chk("undo_off_cnt", 64'(move_cnt), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
